// File: rtl/alu_sequencer.sv
// Program sequencer for the 16-bit accumulator ALU: buffers {OP,IN} instructions and issues one per clock.
// Optional macro ALU_SEQ_ABORT_CLEAR_EN: after an error, drive one OP=1111 cycle to zero the accumulator.
module alu_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WR_EN,
   input  logic [19:0]   WR_DATA,
   output logic          WR_RDY,
   input  logic          CLEAR,
   input  logic          START,
   input  logic          OVF_IN,
   input  logic          DE_IN,
   input  logic          ME_IN,
   output logic [3:0]    OP_OUT,
   output logic [15:0]   IN_OUT,
   output logic          BUSY,
   output logic          DONE,
   output logic [1:0]    ERR,
   output logic [AW:0]   PC,
   output logic [AW:0]   COUNT
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] ABORT = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;
   localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

   logic [1:0]  state;
   logic [AW:0] len;
   logic [19:0] mem [DEPTH];

   logic        wr_acc, sub_ovf, div0;
   logic [AW:0] cnt_nx, pc_nx;
   logic [19:0] first, nxt;

   // COUNT never exceeds DEPTH, so its top bit alone marks a full buffer
   assign WR_RDY = (state == IDLE) & ~COUNT[AW];

   always_comb begin
      wr_acc  = WR_EN & WR_RDY & ~CLEAR;
      cnt_nx  = CLEAR ? '0 : COUNT + {{AW{1'b0}}, wr_acc};
      // a write landing in the same cycle as START on an empty buffer is entry 0
      first   = (COUNT == '0) ? WR_DATA : mem[0];
      pc_nx   = PC + ONE;
      nxt     = mem[pc_nx[AW-1:0]];
      sub_ovf = (OP_OUT == 4'b0011) & OVF_IN;
      div0    = ((OP_OUT == 4'b0101) | (OP_OUT == 4'b0110)) & (DE_IN | ME_IN);
   end

   always_ff @(posedge CLK) begin
      if (wr_acc)
         mem[COUNT[AW-1:0]] <= WR_DATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         len    <= '0;
         COUNT  <= '0;
         PC     <= '0;
         OP_OUT <= 4'b0000;
         IN_OUT <= '0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         ERR    <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               COUNT <= cnt_nx;
               if (START && cnt_nx != '0) begin
                  len    <= cnt_nx;
                  ERR    <= 2'b00;
                  PC     <= '0;
                  OP_OUT <= first[19:16];
                  IN_OUT <= first[15:0];
                  BUSY   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (sub_ovf || div0) begin
                  ERR <= sub_ovf ? 2'b01 : 2'b10;
`ifdef ALU_SEQ_ABORT_CLEAR_EN
                  OP_OUT <= 4'b1111;
                  IN_OUT <= '0;
                  state  <= ABORT;
`else
                  OP_OUT <= 4'b0000;
                  IN_OUT <= '0;
                  BUSY   <= 1'b0;
                  DONE   <= 1'b1;
                  state  <= FIN;
`endif
               end else if (PC == len - ONE) begin
                  OP_OUT <= 4'b0000;
                  IN_OUT <= '0;
                  BUSY   <= 1'b0;
                  DONE   <= 1'b1;
                  state  <= FIN;
               end else begin
                  PC     <= pc_nx;
                  OP_OUT <= nxt[19:16];
                  IN_OUT <= nxt[15:0];
               end
            end
            ABORT: begin
               OP_OUT <= 4'b0000;
               IN_OUT <= '0;
               BUSY   <= 1'b0;
               DONE   <= 1'b1;
               state  <= FIN;
            end
            default: begin
               DONE  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: accumulator stub, trace-predicting model, per-cycle compare.
module tb_alu_sequencer;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          CLK, RST, WR_EN, CLEAR, START, OVF_IN, DE_IN, ME_IN;
   logic [19:0]   WR_DATA;
   logic          WR_RDY, BUSY, DONE;
   logic [3:0]    OP_OUT;
   logic [15:0]   IN_OUT;
   logic [1:0]    ERR;
   logic [AW:0]   PC, COUNT;

   alu_sequencer #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_RDY(WR_RDY),
      .CLEAR(CLEAR), .START(START), .OVF_IN(OVF_IN), .DE_IN(DE_IN), .ME_IN(ME_IN),
      .OP_OUT(OP_OUT), .IN_OUT(IN_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .PC(PC), .COUNT(COUNT));

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   // datapath stub: 32-bit accumulator with raw error flags
   function automatic logic [31:0] alu_f(logic [31:0] a, logic [3:0] op, logic [15:0] in);
      logic [31:0] b;
      b = {16'h0, in};
      case (op)
         4'h2: return a + b;
         4'h3: return a - b;
         4'h4: return a * b;
         4'h5: return (in == 0) ? 32'hFFFF_FFFF : a / b;
         4'h6: return (in == 0) ? 32'hFFFF_FFFF : a % b;
         4'hF: return 32'h0;
         default: return a;
      endcase
   endfunction

   function automatic logic [1:0] err_f(logic [31:0] a, logic [3:0] op, logic [15:0] in);
      if (op == 4'h3 && {16'h0, in} > a) return 2'b01;
      if ((op == 4'h5 || op == 4'h6) && in == 0) return 2'b10;
      return 2'b00;
   endfunction

   logic [31:0] acc = 0;
   always @(posedge CLK) acc <= alu_f(acc, OP_OUT, IN_OUT);
   always_comb begin
      OVF_IN = (OP_OUT == 4'h3) && ({16'h0, IN_OUT} > acc);
      DE_IN  = (OP_OUT == 4'h5) && (IN_OUT == 0);
      ME_IN  = (OP_OUT == 4'h6) && (IN_OUT == 0);
   end

   typedef struct {
      logic [3:0]  op;
      logic [15:0] in;
      int          pc;
      bit          busy, done, chk;
      logic [1:0]  err;
   } exp_t;

   exp_t        q[$];
   logic [19:0] prog [DEPTH];
   int          mcount = 0;
   logic [1:0]  merr = 2'b00;
   bit          was_run = 0;
   int          checks = 0, errors = 0;

   // expected per-cycle trace of a whole run, from the program and the accumulator at START
   task automatic launch();
      logic [31:0] a;
      logic [1:0]  er;
      exp_t        e;
      a  = acc;
      er = 2'b00;
      for (int i = 0; i < mcount; i++) begin
         e.op = prog[i][19:16]; e.in = prog[i][15:0]; e.pc = i;
         e.busy = 1; e.done = 0; e.chk = 1; e.err = 2'b00;
         q.push_back(e);
         er = err_f(a, e.op, e.in);
         if (er != 2'b00) break;
         a = alu_f(a, e.op, e.in);
      end
`ifdef ALU_SEQ_ABORT_CLEAR_EN
      if (er != 2'b00) begin
         e.op = 4'hF; e.in = 0; e.pc = 0; e.busy = 1; e.done = 0; e.chk = 0; e.err = er;
         q.push_back(e);
      end
`endif
      e.op = 4'h0; e.in = 0; e.pc = 0; e.busy = 0; e.done = 1; e.chk = 0; e.err = er;
      q.push_back(e);
      merr = er;
   endtask

   initial begin
      forever begin
         exp_t e;
         bit   bad;
         bit   rdy;
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            was_run = 1;
         end else begin
            e.op = 4'h0; e.in = 0; e.pc = 0; e.busy = 0; e.done = 0; e.chk = 0; e.err = merr;
            was_run = 0;
         end
         rdy = !was_run && (mcount < DEPTH);
         bad = (OP_OUT !== e.op) || (BUSY !== e.busy) || (DONE !== e.done) ||
               (ERR !== e.err) || (COUNT !== (AW+1)'(mcount)) || (WR_RDY !== rdy);
         if (e.chk) bad = bad || (IN_OUT !== e.in) || (int'(PC) != e.pc);
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL cycle t=%0t: got op=%h in=%h pc=%0d busy=%b done=%b err=%b cnt=%0d rdy=%b, want op=%h in=%h pc=%0d busy=%b done=%b err=%b cnt=%0d rdy=%b",
                     $time, OP_OUT, IN_OUT, PC, BUSY, DONE, ERR, COUNT, WR_RDY,
                     e.op, e.in, e.pc, e.busy, e.done, e.err, mcount, rdy);
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic cyc(bit we, logic [19:0] d, bit cl, bit st);
      WR_EN = we; WR_DATA = d; CLEAR = cl; START = st;
      @(posedge CLK); #1;
      if (!was_run && !RST) begin
         if (cl) mcount = 0;
         else if (we && mcount < DEPTH) begin
            prog[mcount] = d;
            mcount++;
         end
         if (st && mcount > 0) launch();
      end
      WR_EN = 0; CLEAR = 0; START = 0; WR_DATA = 0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         cyc(0, 0, 0, 0);
         n++;
      end
      if (q.size() > 0) begin
         checks++; errors++;
         $display("FAIL run_timeout: %0d entries left, want 0", q.size());
         q.delete();
      end
      cyc(0, 0, 0, 0);
   endtask

   function automatic logic [19:0] rnd_instr();
      logic [3:0] ops [7];
      ops = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
      return {ops[$urandom_range(0, 6)], 16'($urandom_range(0, 7))};
   endfunction

   initial begin
      int busy_n, done_at;
      RST = 1; WR_EN = 0; CLEAR = 0; START = 0; WR_DATA = 0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_op", 32'(OP_OUT), 0);
      chk("reset_count", 32'(COUNT), 0);
      chk("reset_pc", 32'(PC), 0);
      chk("reset_busy_done_err", {BUSY, DONE, ERR}, 0);
      RST = 0;

      // normal 3-instruction run: 0 + 5, * 4
      cyc(1, {4'hF, 16'd0}, 0, 0);
      cyc(1, {4'h2, 16'd5}, 0, 0);
      cyc(1, {4'h4, 16'd4}, 0, 0);
      cyc(0, 0, 0, 1);
      busy_n = 0; done_at = -1;
      for (int j = 0; j < 6; j++) begin
         @(negedge CLK);
         if (BUSY) busy_n++;
         if (DONE && done_at < 0) done_at = j;
      end
      @(posedge CLK); #1;
      chk("run1_busy_cycles", busy_n, 3);
      chk("run1_done_cycle", done_at, 3);
      chk("run1_acc", acc, 20);
      chk("run1_err", 32'(ERR), 0);

      // rerun without reload, then append one entry together with START
      cyc(0, 0, 0, 1);
      wait_idle();
      chk("rerun_acc", acc, 20);
      cyc(1, {4'h2, 16'd1}, 0, 1);
      wait_idle();
      chk("wr_start_acc", acc, 21);

      // subtract overflow on the last instruction
      cyc(0, 0, 1, 0);
      cyc(1, {4'hF, 16'd0}, 0, 0);
      cyc(1, {4'h2, 16'd3}, 0, 0);
      cyc(1, {4'h3, 16'd5}, 0, 0);
      cyc(0, 0, 0, 1);
      wait_idle();
      chk("ovf_err", 32'(ERR), 1);
`ifdef ALU_SEQ_ABORT_CLEAR_EN
      chk("ovf_acc", acc, 0);
`else
      chk("ovf_acc", acc, 32'hFFFF_FFFE);
`endif

      // divide by zero
      cyc(0, 0, 1, 0);
      cyc(1, {4'hF, 16'd0}, 0, 0);
      cyc(1, {4'h2, 16'd9}, 0, 0);
      cyc(1, {4'h5, 16'd0}, 0, 0);
      cyc(1, {4'h2, 16'd1}, 0, 0);
      cyc(0, 0, 0, 1);
      wait_idle();
      chk("div0_err", 32'(ERR), 2);

      // fill, overflow write, clear, empty start
      cyc(0, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) cyc(1, rnd_instr(), 0, 0);
      chk("full_rdy", 32'(WR_RDY), 0);
      cyc(1, {4'h2, 16'd1}, 0, 0);
      chk("full_count", 32'(COUNT), DEPTH);
      cyc(0, 0, 1, 0);
      chk("clear_count", 32'(COUNT), 0);
      cyc(0, 0, 0, 1);
      chk("empty_start_busy", 32'(BUSY), 0);

      // reset in the second run cycle
      for (int i = 0; i < 4; i++) cyc(1, {4'h2, 16'd1}, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      RST = 1;
      #1;
      q.delete(); mcount = 0; merr = 2'b00;
      chk("rst_op", 32'(OP_OUT), 0);
      chk("rst_busy_count", {BUSY, 27'd0, COUNT}, 0);
      @(posedge CLK); #1;
      RST = 0;
      cyc(0, 0, 0, 0);

      // randomized programs with junk inputs while running
      for (int it = 0; it < 80; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) cyc(0, 0, 1, 0);
         else if (r <= 5) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) cyc(1, rnd_instr(), 0, 0);
         end else if (r <= 8) begin
            int g;
            cyc(($urandom_range(0, 1) == 1), rnd_instr(), 0, 1);
            g = 0;
            while (q.size() > 0 && g < 100) begin
               cyc(($urandom_range(0, 3) == 0), rnd_instr(), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0));
               g++;
            end
         end else cyc(0, 0, 1, 1);
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
